// File: rtl/spi_shifter.sv
// spi_shifter: SPI data path.
// Holds the CPU transmit byte, serialises it on MOSI while capturing MISO, and
// hands the received byte back to the CPU read side. Flags write collisions
// (CPU write during a frame) and overruns (new byte before the old was read).
module spi_shifter #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Shifter_en,
   input  logic              SPDR_rd_en,
   input  logic              SPDR_wr_en,
   input  logic              sample_stb,
   input  logic              shift_stb,
   input  logic              LSBFE,
   input  logic              MISO,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_re,
   input  logic              flag_clr,
   output logic              MOSI,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_empty,
   output logic              WCOL,
   output logic              OVR
);

   // Bit counter saturates at the frame width; extra shift strobes are ignored.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Next shift-register value for one bit step in the selected bit order.
   function automatic logic [DATA_W-1:0] shift_next(
      input logic [DATA_W-1:0] cur,
      input logic              bit_in,
      input logic              lsb_first
   );
      logic [DATA_W-1:0] res;
      if (lsb_first) begin
         res = {bit_in, cur[DATA_W-1:1]};
      end else begin
         res = {cur[DATA_W-2:0], bit_in};
      end
      return res;
   endfunction

   // State registers
   logic [DATA_W-1:0] shreg_r;
   logic [DATA_W-1:0] tx_buf_r;
   logic              tx_full_r;
   logic [DATA_W-1:0] rx_data_r;
   logic              rx_unread_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic              miso_lat_r;
   logic              rx_valid_r;
   logic              wcol_r;
   logic              ovr_r;
   logic              wr_en_d_r;

   // Decoded events for the current cycle
   logic              cpu_wr_ok_s;
   logic              wcol_set_s;
   logic              load_s;
   logic              sample_s;
   logic              shift_s;
   logic              shift_in_s;
   logic              commit_s;
   logic              ovr_set_s;

   // Decode control levels and strobes into single-cycle events.
   always_comb begin
      cpu_wr_ok_s = 1'b0;
      wcol_set_s  = 1'b0;
      load_s      = 1'b0;
      sample_s    = 1'b0;
      shift_s     = 1'b0;
      shift_in_s  = 1'b0;
      commit_s    = 1'b0;
      ovr_set_s   = 1'b0;

      if (cpu_we) begin
         cpu_wr_ok_s = ~Shifter_en;
         wcol_set_s  = Shifter_en;
      end else begin
         cpu_wr_ok_s = 1'b0;
         wcol_set_s  = 1'b0;
      end

      load_s   = SPDR_rd_en & tx_full_r & ~Shifter_en;
      sample_s = Shifter_en & sample_stb;
      shift_s  = Shifter_en & shift_stb & (bit_cnt_r < CNT_MAX);

      // A coincident sample strobe delivers the live pin, not the stale latch.
      if (sample_stb) begin
         shift_in_s = MISO;
      end else begin
         shift_in_s = miso_lat_r;
      end

      commit_s = SPDR_wr_en & ~wr_en_d_r;
      // A same-cycle CPU read acknowledges the old byte, so no overrun.
      ovr_set_s = commit_s & rx_unread_r & ~cpu_re;
   end

   // Transmit buffer: CPU writes accepted only outside a frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_buf_r <= {DATA_W{1'b0}};
      end else if (cpu_wr_ok_s) begin
         tx_buf_r <= cpu_wdata;
      end else begin
         tx_buf_r <= tx_buf_r;
      end
   end

   // Transmit-full flag: a same-cycle write keeps it set over a load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_full_r <= 1'b0;
      end else if (cpu_wr_ok_s) begin
         tx_full_r <= 1'b1;
      end else if (load_s) begin
         tx_full_r <= 1'b0;
      end else begin
         tx_full_r <= tx_full_r;
      end
   end

   // Shift register: parallel load from tx buffer or one-bit shift.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg_r <= {DATA_W{1'b0}};
      end else if (load_s) begin
         shreg_r <= tx_buf_r;
      end else if (shift_s) begin
         shreg_r <= shift_next(shreg_r, shift_in_s, LSBFE);
      end else begin
         shreg_r <= shreg_r;
      end
   end

   // Bit counter: cleared on load, counts shifts up to the frame width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt_r <= {CNT_W{1'b0}};
      end else if (load_s) begin
         bit_cnt_r <= {CNT_W{1'b0}};
      end else if (shift_s) begin
         bit_cnt_r <= bit_cnt_r + CNT_ONE;
      end else begin
         bit_cnt_r <= bit_cnt_r;
      end
   end

   // MISO latch captured on the sample strobe during a frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         miso_lat_r <= 1'b0;
      end else if (sample_s) begin
         miso_lat_r <= MISO;
      end else begin
         miso_lat_r <= miso_lat_r;
      end
   end

   // Commit edge detector history for SPDR_wr_en.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en_d_r <= 1'b0;
      end else begin
         wr_en_d_r <= SPDR_wr_en;
      end
   end

   // Receive data and one-cycle valid pulse on commit (partial frames included).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data_r  <= {DATA_W{1'b0}};
         rx_valid_r <= 1'b0;
      end else if (commit_s) begin
         rx_data_r  <= shreg_r;
         rx_valid_r <= 1'b1;
      end else begin
         rx_data_r  <= rx_data_r;
         rx_valid_r <= 1'b0;
      end
   end

   // Unread marker: set on commit, cleared by a CPU read; commit wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_unread_r <= 1'b0;
      end else if (commit_s) begin
         rx_unread_r <= 1'b1;
      end else if (cpu_re) begin
         rx_unread_r <= 1'b0;
      end else begin
         rx_unread_r <= rx_unread_r;
      end
   end

   // Sticky write-collision flag; a same-cycle set beats the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcol_r <= 1'b0;
      end else if (wcol_set_s) begin
         wcol_r <= 1'b1;
      end else if (flag_clr) begin
         wcol_r <= 1'b0;
      end else begin
         wcol_r <= wcol_r;
      end
   end

   // Sticky overrun flag; a same-cycle set beats the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovr_r <= 1'b0;
      end else if (ovr_set_s) begin
         ovr_r <= 1'b1;
      end else if (flag_clr) begin
         ovr_r <= 1'b0;
      end else begin
         ovr_r <= ovr_r;
      end
   end

   // Serial output idles high outside a frame; bit order chosen by LSBFE.
   always_comb begin
      MOSI = 1'b1;
      if (Shifter_en) begin
         if (LSBFE) begin
            MOSI = shreg_r[0];
         end else begin
            MOSI = shreg_r[DATA_W-1];
         end
      end else begin
         MOSI = 1'b1;
      end
   end

   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;
   assign tx_empty = ~tx_full_r;
   assign WCOL     = wcol_r;
   assign OVR      = ovr_r;

endmodule

// File: tb/tb_spi_shifter.sv
// tb_spi_shifter: directed self-checking bench for spi_shifter.
module tb_spi_shifter;

   logic       clk;
   logic       rst;
   logic       Shifter_en;
   logic       SPDR_rd_en;
   logic       SPDR_wr_en;
   logic       sample_stb;
   logic       shift_stb;
   logic       LSBFE;
   logic       MISO;
   logic       cpu_we;
   logic [7:0] cpu_wdata;
   logic       cpu_re;
   logic       flag_clr;
   logic       MOSI;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_empty;
   logic       WCOL;
   logic       OVR;

   int tests_run;
   int tests_failed;

   spi_shifter #(.DATA_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .Shifter_en(Shifter_en), .SPDR_rd_en(SPDR_rd_en),
      .SPDR_wr_en(SPDR_wr_en), .sample_stb(sample_stb), .shift_stb(shift_stb),
      .LSBFE(LSBFE), .MISO(MISO), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_re(cpu_re), .flag_clr(flag_clr), .MOSI(MOSI), .rx_data(rx_data),
      .rx_valid(rx_valid), .tx_empty(tx_empty), .WCOL(WCOL), .OVR(OVR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [7:0] b);
      cpu_we = 1'b1; cpu_wdata = b;
      tick();
      cpu_we = 1'b0;
   endtask

   task automatic load();
      SPDR_rd_en = 1'b1;
      tick();
      SPDR_rd_en = 1'b0;
   endtask

   // separate sample strobe then shift strobe
   task automatic shift_bit(input logic b);
      MISO = b; sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0; shift_stb = 1'b1;
      tick();
      shift_stb = 1'b0;
   endtask

   task automatic commit();
      SPDR_wr_en = 1'b1;
      tick();
      SPDR_wr_en = 1'b0;
      tick();
   endtask

   task automatic cpu_read();
      cpu_re = 1'b1;
      tick();
      cpu_re = 1'b0;
   endtask

   task automatic clear_flags();
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
   endtask

   // full frame: write, load, 8 shifts, commit (bit order from LSBFE)
   task automatic run_frame(input logic [7:0] tx, input logic [7:0] rx);
      cpu_write(tx);
      load();
      Shifter_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         shift_bit(LSBFE ? rx[i] : rx[7-i]);
      end
      Shifter_en = 1'b0;
      commit();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      tests_run++;
      if (rx_data !== 8'h00 || rx_valid !== 1'b0 || WCOL !== 1'b0 || OVR !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_regs: rx_data=%h rx_valid=%b WCOL=%b OVR=%b, required 00 0 0 0",
                  rx_data, rx_valid, WCOL, OVR);
      end
      tests_run++;
      if (MOSI !== 1'b1 || tx_empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_out: MOSI=%b tx_empty=%b, required 1 1", MOSI, tx_empty);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_msb_first();
      logic [7:0] tx;
      logic [7:0] rx;
      int pulses;
      tx = 8'hA5; rx = 8'h3C; LSBFE = 1'b0;
      cpu_write(tx);
      tests_run++;
      if (tx_empty !== 1'b0) begin
         tests_failed++;
         $display("FAIL msb_tx_full: tx_empty=%b, required 0", tx_empty);
      end
      load();
      tests_run++;
      if (tx_empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL msb_load_empty: tx_empty=%b, required 1", tx_empty);
      end
      Shifter_en = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         if (MOSI !== tx[7-i]) begin
            tests_failed++;
            $display("FAIL msb_mosi_bit%0d: got %b, required %b", i, MOSI, tx[7-i]);
         end
         shift_bit(rx[7-i]);
      end
      Shifter_en = 1'b0;
      #1;
      tests_run++;
      if (MOSI !== 1'b1) begin
         tests_failed++;
         $display("FAIL msb_mosi_idle: got %b, required 1", MOSI);
      end
      SPDR_wr_en = 1'b1;
      tick();
      tests_run++;
      if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL msb_commit: rx_data=%h rx_valid=%b, required 3c 1", rx_data, rx_valid);
      end
      pulses = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rx_valid === 1'b1) pulses++;
      end
      SPDR_wr_en = 1'b0;
      tick();
      tests_run++;
      if (pulses !== 1) begin
         tests_failed++;
         $display("FAIL msb_valid_pulses: got %0d, required 1", pulses);
      end
      cpu_read();
   endtask

   task automatic test_lsb_first();
      logic [7:0] rx;
      rx = 8'h80; LSBFE = 1'b1;
      cpu_write(8'h01);
      load();
      Shifter_en = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         if (MOSI !== ((i == 0) ? 1'b1 : 1'b0)) begin
            tests_failed++;
            $display("FAIL lsb_mosi_bit%0d: got %b, required %b", i, MOSI, (i == 0));
         end
         shift_bit(rx[i]);
      end
      Shifter_en = 1'b0;
      commit();
      tests_run++;
      if (rx_data !== 8'h80 || OVR !== 1'b0) begin
         tests_failed++;
         $display("FAIL lsb_rx: rx_data=%h OVR=%b, required 80 0", rx_data, OVR);
      end
      cpu_read();
      LSBFE = 1'b0;
   endtask

   task automatic test_wcol();
      cpu_write(8'hC3);
      Shifter_en = 1'b1;
      cpu_write(8'h55);
      tests_run++;
      if (WCOL !== 1'b1 || tx_empty !== 1'b0) begin
         tests_failed++;
         $display("FAIL wcol_set: WCOL=%b tx_empty=%b, required 1 0", WCOL, tx_empty);
      end
      clear_flags();
      tests_run++;
      if (WCOL !== 1'b0) begin
         tests_failed++;
         $display("FAIL wcol_clr: WCOL=%b, required 0", WCOL);
      end
      // set and clear in the same cycle: set wins
      cpu_we = 1'b1; cpu_wdata = 8'h66; flag_clr = 1'b1;
      tick();
      cpu_we = 1'b0; flag_clr = 1'b0;
      tests_run++;
      if (WCOL !== 1'b1) begin
         tests_failed++;
         $display("FAIL wcol_set_beats_clr: WCOL=%b, required 1", WCOL);
      end
      clear_flags();
      Shifter_en = 1'b0;
      load();
      // commit without shifting: tx_buf must still hold C3
      commit();
      tests_run++;
      if (rx_data !== 8'hC3 || WCOL !== 1'b0) begin
         tests_failed++;
         $display("FAIL wcol_txbuf_kept: rx_data=%h WCOL=%b, required c3 0", rx_data, WCOL);
      end
      cpu_read();
   endtask

   task automatic test_overrun();
      run_frame(8'h12, 8'h11);
      run_frame(8'h34, 8'h22);
      tests_run++;
      if (OVR !== 1'b1 || rx_data !== 8'h22) begin
         tests_failed++;
         $display("FAIL ovr_set: OVR=%b rx_data=%h, required 1 22", OVR, rx_data);
      end
      cpu_read();
      tests_run++;
      if (OVR !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovr_sticky: OVR=%b, required 1", OVR);
      end
      clear_flags();
      tests_run++;
      if (OVR !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovr_clr: OVR=%b, required 0", OVR);
      end
      // unread byte, then commit coinciding with cpu_re: no overrun
      commit();
      cpu_re = 1'b1; SPDR_wr_en = 1'b1;
      tick();
      cpu_re = 1'b0; SPDR_wr_en = 1'b0;
      tick();
      tests_run++;
      if (OVR !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovr_re_same_cycle: OVR=%b, required 0", OVR);
      end
      cpu_read();
   endtask

   task automatic test_coincident();
      logic [7:0] rx;
      rx = 8'h5A;
      cpu_write(8'h00);
      load();
      Shifter_en = 1'b1;
      // preload latch with a value opposite to the first live bit
      MISO = 1'b1; sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      for (int i = 0; i < 9; i++) begin
         MISO = (i < 8) ? rx[7-i] : 1'b1;
         sample_stb = 1'b1; shift_stb = 1'b1;
         tick();
         sample_stb = 1'b0; shift_stb = 1'b0;
      end
      #1;
      tests_run++;
      if (MOSI !== 1'b0) begin
         tests_failed++;
         $display("FAIL coinc_mosi_after9: got %b, required 0", MOSI);
      end
      Shifter_en = 1'b0;
      commit();
      tests_run++;
      if (rx_data !== 8'h5A) begin
         tests_failed++;
         $display("FAIL coinc_rx: rx_data=%h, required 5a", rx_data);
      end
      cpu_read();
   endtask

   task automatic test_reset_midframe();
      cpu_write(8'h99);
      load();
      cpu_write(8'h77);
      run_frame_partial();
      cpu_we = 1'b1; cpu_wdata = 8'h44;
      tick();
      cpu_we = 1'b0;
      tests_run++;
      if (WCOL !== 1'b1 || tx_empty !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_pre: WCOL=%b tx_empty=%b, required 1 0", WCOL, tx_empty);
      end
      #2;
      rst = 1'b0; Shifter_en = 1'b0;
      #1;
      tests_run++;
      if (MOSI !== 1'b1 || tx_empty !== 1'b1 || WCOL !== 1'b0 || rx_data !== 8'h00 ||
          OVR !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_async: MOSI=%b tx_empty=%b WCOL=%b rx_data=%h OVR=%b, required 1 1 0 00 0",
                  MOSI, tx_empty, WCOL, rx_data, OVR);
      end
      tick();
      rst = 1'b1;
      tick();
      // no pending byte: load does nothing, cleared shreg is delivered
      load();
      commit();
      tests_run++;
      if (rx_data !== 8'h00 || OVR !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_cleared: rx_data=%h OVR=%b, required 00 0", rx_data, OVR);
      end
      cpu_read();
      run_frame(8'h6B, 8'hD2);
      tests_run++;
      if (rx_data !== 8'hD2 || OVR !== 1'b0 || tx_empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstmid_after: rx_data=%h OVR=%b tx_empty=%b, required d2 0 1",
                  rx_data, OVR, tx_empty);
      end
   endtask

   // start a frame on the loaded 0x99 and shift 4 bits
   task automatic run_frame_partial();
      Shifter_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         shift_bit(1'b0);
      end
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      Shifter_en = 1'b0; SPDR_rd_en = 1'b0; SPDR_wr_en = 1'b0;
      sample_stb = 1'b0; shift_stb = 1'b0; LSBFE = 1'b0; MISO = 1'b0;
      cpu_we = 1'b0; cpu_wdata = 8'h00; cpu_re = 1'b0; flag_clr = 1'b0;
      rst = 1'b1;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_wcol();
      test_overrun();
      test_coincident();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
